pipeline_control: RTL

Central hazard and memory-port sequencer for the pipelined CPU core. It owns the single shared SRAM port, alternating it between instruction fetch (IF) and data access (MEM) with a fixed wait-state count. It drives every stall, hold and flush signal of the stage registers: load-use bubbles, jump flushes and structural-hazard freezes. It replaces the scattered per-hazard clear logic and sits beside the PC, IF/ID, ID/EX and EX/MEM registers.

---
 rtl/pipeline_control_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 58 +++++
 rtl/pipeline_control.sv | 81 ++++++++
 3 files changed

// File: rtl/pipeline_control_pkg.sv
// Shared encodings for the pipeline sequencer: arbiter states and the
// polarity of the stall, hold, clear and jump controls.
package pipeline_control_pkg;

  localparam int CNT_W = 3;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DATA  = 1'b1
  } arb_state_t;

  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;
  localparam logic HOLD_ENABLE   = 1'b1;
  localparam logic HOLD_DISABLE  = 1'b0;
  localparam logic CLEAR_ENABLE  = 1'b1;
  localparam logic CLEAR_DISABLE = 1'b0;
  localparam logic PC_JUMP       = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Owner of the single SRAM port. It alternates the port between fetch and
// data access, where each access lasts MEM_WAIT+1 cycles. It flags the one
// cycle per fetch on which the pipeline may advance.
module mem_port_arbiter
  import pipeline_control_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic data_req,
  output logic if_grant,
  output logic mem_grant,
  output logic adv
);

  localparam logic [CNT_W-1:0] LAST_CNT = MEM_WAIT[CNT_W-1:0];

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last;

  // State and wait counter; reset aborts any access and restarts a fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter wrap and grant/advance generation. Outputs are
  // held inactive while reset is asserted.
  always_comb begin
    last      = (cnt == LAST_CNT);
    cnt_nxt   = last ? '0 : cnt + 1'b1;
    state_nxt = state;
    if_grant  = 1'b0;
    mem_grant = 1'b0;
    adv       = 1'b0;
    case (state)
      S_FETCH: begin
        if_grant = rst;
        adv      = rst & last;
        // The EX memory op enters MEM on the advance edge.
        if (last && data_req) state_nxt = S_DATA;
      end
      S_DATA: begin
        mem_grant = rst;
        if (last) state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: rtl/pipeline_control.sv
// Hazard sequencer for the pipelined core. On top of the memory-port
// arbiter it resolves load-use bubbles, jump flushes and structural
// freezes into the stall, hold and clear controls of the stage registers.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int MEM_WAIT   = 1,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_jump_en,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_use,
  input  logic                  id_rt_use,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  if_grant,
  output logic                  mem_grant,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_clear,
  output logic                  id_ex_clear,
  output logic                  pipe_hold
);

  logic adv;
  logic lu;

  mem_port_arbiter #(
    .MEM_WAIT (MEM_WAIT)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .data_req  (ex_mem_read | ex_mem_write),
    .if_grant  (if_grant),
    .mem_grant (mem_grant),
    .adv       (adv)
  );

  // Load in EX whose destination is read by the instruction in ID.
  function automatic logic load_use(
    input logic                  rd_load,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  rs_use,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  rt_use
  );
    return rd_load && (rd != '0) &&
           ((rs_use && (rs == rd)) || (rt_use && (rt == rd)));
  endfunction

  // Hazard priority: freeze everything outside advance cycles; on advance,
  // a load-use bubble beats a jump flush, which beats normal flow. A jump
  // lost to a bubble is re-resolved because ID is held.
  always_comb begin
    lu          = load_use(ex_mem_read, ex_rd, id_rs, id_rs_use, id_rt, id_rt_use);
    pc_stall    = STALL_ENABLE;
    if_id_stall = STALL_ENABLE;
    pipe_hold   = HOLD_ENABLE;
    if_id_clear = CLEAR_DISABLE;
    id_ex_clear = CLEAR_DISABLE;
    if (adv) begin
      pipe_hold = HOLD_DISABLE;
      if (lu) begin
        id_ex_clear = CLEAR_ENABLE;
      end else if (pc_jump_en == PC_JUMP) begin
        pc_stall    = STALL_DISABLE;
        if_id_stall = STALL_DISABLE;
        if_id_clear = CLEAR_ENABLE;
      end else begin
        pc_stall    = STALL_DISABLE;
        if_id_stall = STALL_DISABLE;
      end
    end
  end

endmodule
